uart_cmd_rx: RTL and testbench

//  UART receiver on the RxD pin; the inbound counterpart of the screen-print transmitter on TxD.

---
 rtl/syria_pkg.sv | 58 +++++
 rtl/rx_tick_gen.sv | 29 ++
 rtl/uart_cmd_rx.sv | 172 +++++++++++++++++
 tb/tb_uart_cmd_rx.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/syria_pkg.sv
// Shared types, ASCII key codes and baud divider helper for the UART command receiver.
package syria_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_t;

    typedef struct packed {
        logic up;
        logic down;
        logic left;
        logic right;
        logic center;
        logic pause;
    } cmd_t;

    localparam logic [7:0] KEY_UP_L    = 8'h77;
    localparam logic [7:0] KEY_UP_U    = 8'h57;
    localparam logic [7:0] KEY_DOWN_L  = 8'h73;
    localparam logic [7:0] KEY_DOWN_U  = 8'h53;
    localparam logic [7:0] KEY_LEFT_L  = 8'h61;
    localparam logic [7:0] KEY_LEFT_U  = 8'h41;
    localparam logic [7:0] KEY_RIGHT_L = 8'h64;
    localparam logic [7:0] KEY_RIGHT_U = 8'h44;
    localparam logic [7:0] KEY_PAUSE_L = 8'h70;
    localparam logic [7:0] KEY_PAUSE_U = 8'h50;
    localparam logic [7:0] KEY_SPACE   = 8'h20;
    localparam logic [7:0] KEY_CR      = 8'h0D;

    function automatic int unsigned calc_div(
        input int unsigned clk_hz,
        input int unsigned baud,
        input int unsigned os
    );
        return clk_hz / (baud * os);
    endfunction

    function automatic cmd_t decode_key(input logic [7:0] key);
        cmd_t c;
        c = '0;
        case (key)
            KEY_UP_L, KEY_UP_U:       c.up     = 1'b1;
            KEY_DOWN_L, KEY_DOWN_U:   c.down   = 1'b1;
            KEY_LEFT_L, KEY_LEFT_U:   c.left   = 1'b1;
            KEY_RIGHT_L, KEY_RIGHT_U: c.right  = 1'b1;
            KEY_SPACE, KEY_CR:        c.center = 1'b1;
            KEY_PAUSE_L, KEY_PAUSE_U: c.pause  = 1'b1;
            default:                  c        = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/rx_tick_gen.sv
// Oversample tick generator: one-clock tick every DIV clocks, held at zero by clr.
module rx_tick_gen #(
    parameter int unsigned DIV = 54
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (cnt == LAST) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + 1'b1;
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_cmd_rx.sv
// UART receiver decoding terminal keys into one-cycle game command pulses.
// Define RX_PARITY_EN for 8E1 frames with even-parity checking (default 8N1).
import syria_pkg::*;

module uart_cmd_rx #(
    parameter int unsigned CLK_HZ     = 100000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RxD,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       cmd_up,
    output logic       cmd_down,
    output logic       cmd_left,
    output logic       cmd_right,
    output logic       cmd_center,
    output logic       cmd_pause,
    output logic       frame_err,
    output logic       parity_err
);

    localparam int unsigned DIV = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int SW = $clog2(OVERSAMPLE);
    localparam logic [SW-1:0] HALF = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] FULL = SW'(OVERSAMPLE - 1);

    rx_state_t     state;
    logic [1:0]    sync;
    logic          rx;
    logic          rx_prev;
    logic          tick;
    logic [SW-1:0] smp;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    cmd_t          cmd;
    logic          par_ok;

    assign rx = sync[1];

    always_ff @(posedge clk) begin
        if (rst) sync <= 2'b11;
        else     sync <= {sync[0], RxD};
    end

    rx_tick_gen #(.DIV(DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (state == IDLE),
        .tick (tick)
    );

`ifdef RX_PARITY_EN
    logic par_bad;
    logic perr_q;
    assign par_ok     = ~par_bad;
    assign parity_err = perr_q;
`else
    assign par_ok     = 1'b1;
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rx_prev    <= 1'b1;
            smp        <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            byte_data  <= '0;
            byte_valid <= 1'b0;
            cmd        <= '0;
            frame_err  <= 1'b0;
`ifdef RX_PARITY_EN
            par_bad    <= 1'b0;
            perr_q     <= 1'b0;
`endif
        end else begin
            rx_prev    <= rx;
            byte_valid <= 1'b0;
            cmd        <= '0;
            frame_err  <= 1'b0;
`ifdef RX_PARITY_EN
            perr_q     <= 1'b0;
`endif
            unique case (state)
                IDLE: begin
                    if (rx_prev && !rx) begin
                        state <= START;
                        smp   <= '0;
                    end
                end
                START: begin
                    if (tick) begin
                        if (smp == HALF) begin
                            smp     <= '0;
                            bit_idx <= '0;
                            state   <= rx ? IDLE : DATA;
                        end else begin
                            smp <= smp + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (smp == FULL) begin
                            smp     <= '0;
                            shift   <= {rx, shift[7:1]};
                            bit_idx <= bit_idx + 1'b1;
                            if (bit_idx == 3'd7) begin
`ifdef RX_PARITY_EN
                                state <= PARITY;
`else
                                state <= STOP;
`endif
                            end
                        end else begin
                            smp <= smp + 1'b1;
                        end
                    end
                end
`ifdef RX_PARITY_EN
                PARITY: begin
                    if (tick) begin
                        if (smp == FULL) begin
                            smp     <= '0;
                            par_bad <= rx ^ (^shift);
                            state   <= STOP;
                        end else begin
                            smp <= smp + 1'b1;
                        end
                    end
                end
`endif
                STOP: begin
                    if (tick) begin
                        if (smp == FULL) begin
                            smp       <= '0;
                            frame_err <= ~rx;
`ifdef RX_PARITY_EN
                            perr_q    <= par_bad;
`endif
                            // Either error suppresses the byte entirely
                            if (rx && par_ok) begin
                                byte_valid <= 1'b1;
                                byte_data  <= shift;
                                cmd        <= decode_key(shift);
                            end
                            state <= rx ? IDLE : BREAK;
                        end else begin
                            smp <= smp + 1'b1;
                        end
                    end
                end
                BREAK: begin
                    if (rx) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign cmd_up     = cmd.up;
    assign cmd_down   = cmd.down;
    assign cmd_left   = cmd.left;
    assign cmd_right  = cmd.right;
    assign cmd_center = cmd.center;
    assign cmd_pause  = cmd.pause;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Directed bench for uart_cmd_rx: key table plus back-to-back, break, glitch and reset cases.
module tb_uart_cmd_rx;
    import syria_pkg::*;

    // Fast line rate keeps the run short: DIV = 4, one bit = 64 clk.
    localparam int unsigned CLK_HZ = 100000000;
    localparam int unsigned BAUD   = 1562500;
    localparam int BIT = 64;

    localparam logic [5:0] C_NONE   = 6'b000000;
    localparam logic [5:0] C_UP     = 6'b100000;
    localparam logic [5:0] C_DOWN   = 6'b010000;
    localparam logic [5:0] C_LEFT   = 6'b001000;
    localparam logic [5:0] C_RIGHT  = 6'b000100;
    localparam logic [5:0] C_CENTER = 6'b000010;
    localparam logic [5:0] C_PAUSE  = 6'b000001;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       RxD = 1'b1;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       cmd_up, cmd_down, cmd_left, cmd_right, cmd_center, cmd_pause;
    logic       frame_err, parity_err;

    uart_cmd_rx #(
        .CLK_HZ     (CLK_HZ),
        .BAUD       (BAUD),
        .OVERSAMPLE (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .RxD        (RxD),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .cmd_up     (cmd_up),
        .cmd_down   (cmd_down),
        .cmd_left   (cmd_left),
        .cmd_right  (cmd_right),
        .cmd_center (cmd_center),
        .cmd_pause  (cmd_pause),
        .frame_err  (frame_err),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] q_data[$];
    logic [5:0] q_cmd[$];
    int n_ferr  = 0;
    int n_perr  = 0;
    int n_stray = 0;

    logic [5:0] cmds;
    assign cmds = {cmd_up, cmd_down, cmd_left, cmd_right, cmd_center, cmd_pause};

    always @(negedge clk) begin
        if (byte_valid) begin
            q_data.push_back(byte_data);
            q_cmd.push_back(cmds);
        end
        if (!byte_valid && cmds != 6'b0) n_stray++;
        if (frame_err) n_ferr++;
        if (parity_err) n_perr++;
    end

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         low_bits;
        int         exp_n;
        logic [5:0] exp_cmd;
        int         exp_ferr;
        logic [7:0] exp_bd;
    } vec_t;

    vec_t vecs[16];

`ifdef RX_PARITY_EN
    logic par_flip = 1'b0;
`endif

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        RxD = b;
        repeat (BIT) @(posedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop,
                              input int low_bits);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef RX_PARITY_EN
        send_bit((^d) ^ par_flip);
`endif
        send_bit(stop);
        if (!stop) begin
            for (int i = 0; i < low_bits; i++) send_bit(1'b0);
        end
        RxD = 1'b1;
    endtask

    task automatic idle(input int bits);
        RxD = 1'b1;
        repeat (bits * BIT) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_mon();
        q_data.delete();
        q_cmd.delete();
        n_ferr  = 0;
        n_perr  = 0;
        n_stray = 0;
    endtask

    function automatic logic [7:0] qd(input int i);
        return (q_data.size() > i) ? q_data[i] : 8'hxx;
    endfunction

    function automatic logic [5:0] qc(input int i);
        return (q_cmd.size() > i) ? q_cmd[i] : 6'hxx;
    endfunction

    initial begin
        #5ms;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{8'h77, 1'b1, 0, 1, C_UP,     0, 8'h77};
        vecs[1]  = '{8'h64, 1'b0, 2, 0, C_NONE,   1, 8'h77};
        vecs[2]  = '{8'h64, 1'b1, 0, 1, C_RIGHT,  0, 8'h64};
        vecs[3]  = '{8'h57, 1'b1, 0, 1, C_UP,     0, 8'h57};
        vecs[4]  = '{8'h73, 1'b1, 0, 1, C_DOWN,   0, 8'h73};
        vecs[5]  = '{8'h53, 1'b1, 0, 1, C_DOWN,   0, 8'h53};
        vecs[6]  = '{8'h61, 1'b1, 0, 1, C_LEFT,   0, 8'h61};
        vecs[7]  = '{8'h44, 1'b1, 0, 1, C_RIGHT,  0, 8'h44};
        vecs[8]  = '{8'h20, 1'b1, 0, 1, C_CENTER, 0, 8'h20};
        vecs[9]  = '{8'h0D, 1'b1, 0, 1, C_CENTER, 0, 8'h0D};
        vecs[10] = '{8'h70, 1'b1, 0, 1, C_PAUSE,  0, 8'h70};
        vecs[11] = '{8'h50, 1'b1, 0, 1, C_PAUSE,  0, 8'h50};
        vecs[12] = '{8'h5A, 1'b1, 0, 1, C_NONE,   0, 8'h5A};
        vecs[13] = '{8'h00, 1'b1, 0, 1, C_NONE,   0, 8'h00};
        vecs[14] = '{8'hFF, 1'b0, 1, 0, C_NONE,   1, 8'h00};
        vecs[15] = '{8'hFF, 1'b1, 0, 1, C_NONE,   0, 8'hFF};

        // Reset state
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("reset_byte_data", 32'(byte_data), 32'h00);
        check("reset_pulses", 32'({byte_valid, cmds, frame_err, parity_err}), 32'h0);
        check("reset_state", 32'(dut.state), 32'(IDLE));
        @(posedge clk);
        rst = 1'b0;
        idle(1);

        for (int v = 0; v < 16; v++) begin
            clear_mon();
            send_frame(vecs[v].data, vecs[v].stop, vecs[v].low_bits);
            idle(2);
            check($sformatf("v%0d_count", v), 32'(q_data.size()), 32'(vecs[v].exp_n));
            if (q_data.size() > 0) begin
                check($sformatf("v%0d_data", v), 32'(qd(0)), 32'(vecs[v].data));
                check($sformatf("v%0d_cmd", v), 32'(qc(0)), 32'(vecs[v].exp_cmd));
            end
            check($sformatf("v%0d_ferr", v), 32'(n_ferr), 32'(vecs[v].exp_ferr));
            check($sformatf("v%0d_perr", v), 32'(n_perr), 32'h0);
            check($sformatf("v%0d_stray", v), 32'(n_stray), 32'h0);
            check($sformatf("v%0d_held", v), 32'(byte_data), 32'(vecs[v].exp_bd));
        end

        // Back-to-back frames with no idle gap
        clear_mon();
        send_frame(8'h41, 1'b1, 0);
        send_frame(8'h5A, 1'b1, 0);
        idle(2);
        check("b2b_count", 32'(q_data.size()), 32'd2);
        check("b2b_data0", 32'(qd(0)), 32'h41);
        check("b2b_cmd0", 32'(qc(0)), 32'(C_LEFT));
        check("b2b_data1", 32'(qd(1)), 32'h5A);
        check("b2b_cmd1", 32'(qc(1)), 32'(C_NONE));

        // Short low glitch is rejected at the start-bit mid sample
        clear_mon();
        RxD = 1'b0;
        repeat (22) @(posedge clk);
        idle(2);
        check("glitch_count", 32'(q_data.size()), 32'd0);
        check("glitch_ferr", 32'(n_ferr), 32'd0);
        check("glitch_state", 32'(dut.state), 32'(IDLE));
        send_frame(8'h20, 1'b1, 0);
        idle(2);
        check("post_glitch_count", 32'(q_data.size()), 32'd1);
        check("post_glitch_cmd", 32'(qc(0)), 32'(C_CENTER));

        // Reset pulse during data bit 4 of 0x73
        clear_mon();
        fork
            send_frame(8'h73, 1'b1, 0);
            begin
                repeat (5 * BIT + BIT / 2) @(posedge clk);
                rst = 1'b1;
                @(posedge clk);
                rst = 1'b0;
            end
        join
        @(negedge clk);
        check("rst_mid_count", 32'(q_data.size()), 32'd0);
        check("rst_mid_ferr", 32'(n_ferr), 32'd0);
        check("rst_mid_stray", 32'(n_stray), 32'd0);
        // Bit 7 of 0x73 is a fresh 1->0 edge after reset; let that frame drain
        idle(12);
        clear_mon();
        send_frame(8'h50, 1'b1, 0);
        idle(2);
        check("post_rst_count", 32'(q_data.size()), 32'd1);
        check("post_rst_data", 32'(qd(0)), 32'h50);
        check("post_rst_cmd", 32'(qc(0)), 32'(C_PAUSE));

`ifdef RX_PARITY_EN
        clear_mon();
        par_flip = 1'b1;
        send_frame(8'h73, 1'b1, 0);
        par_flip = 1'b0;
        idle(2);
        check("par_bad_count", 32'(q_data.size()), 32'd0);
        check("par_bad_perr", 32'(n_perr), 32'd1);
        check("par_bad_ferr", 32'(n_ferr), 32'd0);
        check("par_bad_held", 32'(byte_data), 32'h50);
        clear_mon();
        send_frame(8'h73, 1'b1, 0);
        idle(2);
        check("par_ok_count", 32'(q_data.size()), 32'd1);
        check("par_ok_cmd", 32'(qc(0)), 32'(C_DOWN));
        check("par_ok_perr", 32'(n_perr), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
